// File: rtl/bus_arbiter_n_pkg.sv
// Shared types and helpers for the N-client bus arbiter.
// The FSM state encoding and the scheduling-mode constant live here.
package bus_arbiter_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam logic SCHED_RR = 1'b1;

    // Successor index with wrap from n-1 back to 0.
    function automatic int wrap_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_n_select.sv
// Combinational winner picker: strict priority (lowest value, lowest index on ties)
// or round robin starting at i_rr_ptr and wrapping N-1 -> 0.
module bus_arbiter_n_select
    import bus_arbiter_n_pkg::*;
#(
    parameter int NR_OF_CLIENTS = 4,
    parameter int IDX_W         = 2,
    parameter int PRIO_W        = 2
) (
    input  logic [NR_OF_CLIENTS-1:0]        i_rq,
    input  logic [IDX_W-1:0]                i_rr_ptr,
    input  logic                            i_mode,
    input  logic [NR_OF_CLIENTS*PRIO_W-1:0] i_priorities,
    output logic [IDX_W-1:0]                o_win_idx,
    output logic                            o_win_valid
);

    logic [PRIO_W-1:0] w_prio [NR_OF_CLIENTS];
    logic [IDX_W-1:0]  w_sp_idx;
    logic [PRIO_W-1:0] w_sp_best;
    logic              w_sp_found;
    logic [IDX_W-1:0]  w_rr_idx;
    logic              w_rr_found;
    int                w_cand;

    genvar gi;
    generate
        for (gi = 0; gi < NR_OF_CLIENTS; gi++) begin : g_prio
            assign w_prio[gi] = i_priorities[gi*PRIO_W +: PRIO_W];
        end
    endgenerate

    always_comb begin
        w_sp_idx   = '0;
        w_sp_best  = '0;
        w_sp_found = 1'b0;
        for (int i = 0; i < NR_OF_CLIENTS; i++) begin
            if (i_rq[i[IDX_W-1:0]] && (!w_sp_found || (w_prio[i[IDX_W-1:0]] < w_sp_best))) begin
                w_sp_found = 1'b1;
                w_sp_best  = w_prio[i[IDX_W-1:0]];
                w_sp_idx   = i[IDX_W-1:0];
            end
        end
    end

    // Rotate the search origin to the pointer; candidates never exceed 2N-2 so one subtract wraps.
    always_comb begin
        w_rr_idx   = '0;
        w_rr_found = 1'b0;
        w_cand     = 0;
        for (int k = 0; k < NR_OF_CLIENTS; k++) begin
            w_cand = int'(i_rr_ptr) + k;
            if (w_cand >= NR_OF_CLIENTS) begin
                w_cand = w_cand - NR_OF_CLIENTS;
            end
            if (!w_rr_found && i_rq[w_cand[IDX_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

    assign o_win_idx   = (i_mode == SCHED_RR) ? w_rr_idx : w_sp_idx;
    assign o_win_valid = |i_rq;

endmodule

// File: rtl/bus_arbiter_n.sv
// N-client to single-server bus arbiter with a locked, registered grant,
// one-cycle release bubble, optional timeout and run-time SP/RR selection.
module bus_arbiter_n
    import bus_arbiter_n_pkg::*;
#(
    parameter int                                 DATA_WIDTH        = 8,
    parameter int                                 ADDR_WIDTH        = 4,
    parameter int                                 NR_OF_CLIENTS     = 4,
    parameter int                                 IDX_W             = 2,
    parameter int                                 PRIO_W            = 2,
    parameter logic [NR_OF_CLIENTS*PRIO_W-1:0]    CLIENT_PRIORITIES = 8'hE4,
    parameter int                                 TIMEOUT_CYCLES    = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 sched_mode,
    input  logic [NR_OF_CLIENTS-1:0]             client_rq,
    input  logic [NR_OF_CLIENTS-1:0]             client_wr_ni,
    input  logic [NR_OF_CLIENTS*ADDR_WIDTH-1:0]  client_address,
    input  logic [NR_OF_CLIENTS*DATA_WIDTH-1:0]  client_dataW,
    output logic [NR_OF_CLIENTS-1:0]             client_ack,
    output logic [NR_OF_CLIENTS*DATA_WIDTH-1:0]  client_dataR,
    output logic                                 server_rq,
    input  logic                                 server_ack,
    output logic                                 server_wr_ni,
    output logic [ADDR_WIDTH-1:0]                server_address,
    output logic [DATA_WIDTH-1:0]                server_dataW,
    input  logic [DATA_WIDTH-1:0]                server_dataR,
    output logic                                 grant_valid,
    output logic [IDX_W-1:0]                     grant_idx,
    output logic                                 timeout_err
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_grant_valid;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout_err;

    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_win_valid;
    logic                  w_g_rq;
    logic                  w_tmo_hit;
    logic [ADDR_WIDTH-1:0] w_addr  [NR_OF_CLIENTS];
    logic [DATA_WIDTH-1:0] w_dataw [NR_OF_CLIENTS];

    bus_arbiter_n_select #(
        .NR_OF_CLIENTS (NR_OF_CLIENTS),
        .IDX_W         (IDX_W),
        .PRIO_W        (PRIO_W)
    ) u_select (
        .i_rq         (client_rq),
        .i_rr_ptr     (r_rr_ptr),
        .i_mode       (sched_mode),
        .i_priorities (CLIENT_PRIORITIES),
        .o_win_idx    (w_win_idx),
        .o_win_valid  (w_win_valid)
    );

    assign w_g_rq    = client_rq[r_grant_idx];
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= '0;
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_grant_idx   <= w_win_idx;
                        r_grant_valid <= 1'b1;
                        r_tmo_cnt     <= '0;
                        r_state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Ack beats abort and timeout; an abort (rq dropped) never flags an error.
                    if (server_ack || !w_g_rq || w_tmo_hit) begin
                        r_state       <= ST_RELEASE;
                        r_grant_valid <= 1'b0;
                        r_rr_ptr      <= IDX_W'(wrap_next(int'(r_grant_idx), NR_OF_CLIENTS));
                        r_timeout_err <= !server_ack && w_g_rq && w_tmo_hit;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_tmo_cnt != '1)) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NR_OF_CLIENTS; gi++) begin : g_client
            assign w_addr[gi]  = client_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_dataw[gi] = client_dataW[gi*DATA_WIDTH +: DATA_WIDTH];
            assign client_ack[gi] = r_grant_valid && server_ack && (r_grant_idx == IDX_W'(gi));
            assign client_dataR[gi*DATA_WIDTH +: DATA_WIDTH] =
                (r_grant_valid && (r_grant_idx == IDX_W'(gi))) ? server_dataR : '0;
        end
    endgenerate

    assign server_rq      = r_grant_valid && w_g_rq;
    assign server_wr_ni   = r_grant_valid && client_wr_ni[r_grant_idx];
    assign server_address = r_grant_valid ? w_addr[r_grant_idx]  : '0;
    assign server_dataW   = r_grant_valid ? w_dataw[r_grant_idx] : '0;
    assign grant_valid    = r_grant_valid;
    assign grant_idx      = r_grant_idx;
    assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n (N=5): directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_bus_arbiter_n;

    localparam int N      = 5;
    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int IW     = 3;
    localparam int PW     = 2;
    localparam int TMO    = 16;
    localparam logic [N*PW-1:0] PRIOS = 10'h3E4;

    logic            clk = 1'b0;
    logic            reset;
    logic            sched_mode;
    logic [N-1:0]    client_rq;
    logic [N-1:0]    client_wr_ni;
    logic [N*AW-1:0] client_address;
    logic [N*DW-1:0] client_dataW;
    logic [N-1:0]    client_ack;
    logic [N*DW-1:0] client_dataR;
    logic            server_rq;
    logic            server_ack;
    logic            server_wr_ni;
    logic [AW-1:0]   server_address;
    logic [DW-1:0]   server_dataW;
    logic [DW-1:0]   server_dataR;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;
    logic            timeout_err;

    always #5 clk = ~clk;

    bus_arbiter_n #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NR_OF_CLIENTS (N), .IDX_W (IW),
        .PRIO_W (PW), .CLIENT_PRIORITIES (PRIOS), .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk), .reset (reset), .sched_mode (sched_mode),
        .client_rq (client_rq), .client_wr_ni (client_wr_ni),
        .client_address (client_address), .client_dataW (client_dataW),
        .client_ack (client_ack), .client_dataR (client_dataR),
        .server_rq (server_rq), .server_ack (server_ack), .server_wr_ni (server_wr_ni),
        .server_address (server_address), .server_dataW (server_dataW),
        .server_dataR (server_dataR), .grant_valid (grant_valid),
        .grant_idx (grant_idx), .timeout_err (timeout_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: who holds the bus, whether the post-transfer gap is pending,
    // the fairness pointer and how long the current holder has waited.
    bit           m_busy;
    bit           m_bubble;
    int           m_g;
    int           m_ptr;
    int           m_wait;
    bit           m_tmo;
    logic [N-1:0] m_acked;

    int dut_log[$];
    int dut_cyc[$];
    bit prev_gv = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int prio_of(input int i);
        return int'((PRIOS >> (i*PW)) & 10'h3);
    endfunction

    function automatic int ref_pick(input logic [N-1:0] rq, input logic mode, input int ptr);
        int best;
        best = -1;
        if (mode) begin
            for (int k = 0; k < N; k++) begin
                if (rq[(ptr + k) % N]) return (ptr + k) % N;
            end
            return -1;
        end
        for (int i = 0; i < N; i++) begin
            if (rq[i] && (best < 0 || prio_of(i) < prio_of(best))) best = i;
        end
        return best;
    endfunction

    function automatic int log_at(input int i);
        if (i < 0 || i >= dut_log.size()) return -1;
        return dut_log[i];
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_bubble = 1'b0; m_g = 0; m_ptr = 0;
        m_wait = 0; m_tmo = 1'b0; m_acked = '0;
    endtask

    task automatic model_clock();
        bit done;
        int w;
        done    = 1'b0;
        m_acked = '0;
        m_tmo   = 1'b0;
        if (m_busy) begin
            if (server_ack) begin
                m_acked[m_g] = 1'b1;
                done = 1'b1;
            end else if (!client_rq[m_g]) begin
                done = 1'b1;
            end else if (m_wait == TMO - 1) begin
                m_tmo = 1'b1;
                done = 1'b1;
            end else begin
                m_wait++;
            end
            if (done) begin
                m_busy   = 1'b0;
                m_bubble = 1'b1;
                m_ptr    = (m_g + 1) % N;
            end
        end else if (m_bubble) begin
            m_bubble = 1'b0;
        end else begin
            w = ref_pick(client_rq, sched_mode, m_ptr);
            if (w >= 0) begin
                m_busy = 1'b1;
                m_g    = w;
                m_wait = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0]    e_ack;
        logic [N*DW-1:0] e_dr;
        e_ack = '0;
        e_dr  = '0;
        if (m_busy) begin
            if (server_ack) e_ack[m_g] = 1'b1;
            e_dr[m_g*DW +: DW] = server_dataR;
        end
        check_val("grant_valid", 64'(grant_valid), 64'(m_busy));
        check_val("grant_idx", 64'(grant_idx), 64'(m_g));
        check_val("server_rq", 64'(server_rq), 64'(m_busy && client_rq[m_g]));
        check_val("server_wr_ni", 64'(server_wr_ni), 64'(m_busy && client_wr_ni[m_g]));
        check_val("server_address", 64'(server_address), m_busy ? 64'(client_address[m_g*AW +: AW]) : 64'd0);
        check_val("server_dataW", 64'(server_dataW), m_busy ? 64'(client_dataW[m_g*DW +: DW]) : 64'd0);
        check_val("client_ack", 64'(client_ack), 64'(e_ack));
        check_val("client_dataR", 64'(client_dataR), 64'(e_dr));
        check_val("timeout_err", 64'(timeout_err), 64'(m_tmo));
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        cyc++;
        if (!reset) model_reset();
        else        model_clock();
        #1;
        if (grant_valid && !prev_gv) begin
            dut_log.push_back(int'(grant_idx));
            dut_cyc.push_back(cyc);
            $display("grant client=%0d mode=%0d cyc=%0d", grant_idx, sched_mode, cyc);
        end
        prev_gv = grant_valid;
    endtask

    // ack_dly < 0: server never answers; otherwise ack after ack_dly waiting cycles in GRANT.
    task automatic cycle(input int ack_dly);
        server_ack = m_busy && (ack_dly >= 0) && (m_wait == ack_dly);
        step();
    endtask

    task automatic do_reset();
        client_rq  = '0;
        server_ack = 1'b0;
        reset      = 1'b0;
        model_reset();
        step();
        reset = 1'b1;
        dut_log.delete();
        dut_cyc.delete();
    endtask

    initial begin
        int t_g, t_e;
        logic any_ack;

        reset = 1'b0; sched_mode = 1'b0; client_rq = '1; client_wr_ni = '0;
        client_address = 20'h4C2A1; client_dataW = 40'h5A_3C_96_E1_07;
        server_ack = 1'b0; server_dataR = 8'h00;
        model_reset();

        // Reset with every client requesting, then idle with no requests.
        repeat (3) step();
        reset = 1'b1;
        client_rq = '0;
        repeat (4) cycle(-1);
        check_val("idle_server_rq", 64'(server_rq), 64'd0);
        check_val("idle_grant_valid", 64'(grant_valid), 64'd0);

        // Strict priority: client 1 beats 3 and is re-served while it holds rq.
        do_reset();
        sched_mode = 1'b0;
        client_rq  = 5'b01010;
        repeat (8) cycle(1);
        check_val("sp_first", 64'(log_at(0)), 64'd1);
        check_val("sp_regrant", 64'(log_at(1)), 64'd1);
        client_rq = 5'b01000;
        repeat (4) cycle(1);
        check_val("sp_then3", 64'(log_at(dut_log.size() - 1)), 64'd3);

        // Round robin under full load with a one-cycle ack.
        do_reset();
        sched_mode = 1'b1;
        client_rq  = '1;
        repeat (18) cycle(0);
        check_val("rr_order0", 64'(log_at(0)), 64'd0);
        check_val("rr_order1", 64'(log_at(1)), 64'd1);
        check_val("rr_order2", 64'(log_at(2)), 64'd2);
        check_val("rr_order3", 64'(log_at(3)), 64'd3);
        check_val("rr_order4", 64'(log_at(4)), 64'd4);
        check_val("rr_order5", 64'(log_at(5)), 64'd0);
        check_val("rr_period", (dut_cyc.size() > 1) ? 64'(dut_cyc[1] - dut_cyc[0]) : 64'd0, 64'd3);

        // Timeout: server silent, error pulses TMO cycles after the grant.
        do_reset();
        sched_mode = 1'b1;
        client_rq  = 5'b00100;
        t_g = -1; t_e = -1; any_ack = 1'b0;
        for (int i = 0; i < 40 && t_e < 0; i++) begin
            cycle(-1);
            any_ack = any_ack | (|client_ack);
            if (grant_valid && t_g < 0) t_g = cyc;
            if (timeout_err && t_e < 0) t_e = cyc;
        end
        check_val("tmo_delay", 64'(t_e - t_g), 64'(TMO));
        check_val("tmo_no_ack", 64'(any_ack), 64'd0);
        client_rq = '1;
        repeat (2) cycle(-1);
        check_val("tmo_rr_next", 64'(grant_idx), 64'd3);

        // Abort by the top client wraps the pointer to 0.
        do_reset();
        sched_mode = 1'b1;
        client_rq  = 5'b00010;
        repeat (2) cycle(0);
        client_rq = 5'b10000;
        repeat (2) cycle(-1);
        check_val("abort_grant4", 64'(grant_idx), 64'd4);
        client_rq = 5'b01001;
        repeat (3) cycle(-1);
        check_val("wrap_valid", 64'(grant_valid), 64'd1);
        check_val("wrap_grant0", 64'(grant_idx), 64'd0);

        // Read data routed only to the granted slice in the ack cycle.
        do_reset();
        sched_mode   = 1'b0;
        client_wr_ni = 5'b11011;
        client_rq    = 5'b00100;
        server_dataR = 8'hA5;
        cycle(-1);
        server_ack = 1'b1;
        #1;
        check_val("data_dataR", 64'(client_dataR), 64'h00_00_A5_00_00);
        check_val("data_ack", 64'(client_ack), 64'b00100);
        check_val("data_wr_ni", 64'(server_wr_ni), 64'd0);
        step();
        server_ack = 1'b0;
        client_rq  = '0;

        // Randomized traffic with mode flips, aborts and occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(399) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (m_acked[i])                client_rq[i] = 1'b0;
                    else if (!client_rq[i])        client_rq[i] = ($urandom_range(3) == 0);
                    else if ($urandom_range(47) == 0) client_rq[i] = 1'b0;
                end
                client_wr_ni   = N'($urandom);
                client_address = 20'($urandom);
                client_dataW   = 40'({$urandom, $urandom});
                server_dataR   = 8'($urandom);
                if ($urandom_range(7) == 0) sched_mode = ~sched_mode;
                server_ack = m_busy && ($urandom_range(2) == 0);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
